// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM/WB writes win, MDU results queue and drain
// into idle slots, with a starvation-driven pipeline stall. Optional WB_ARB_PERF_EN adds perf counters.
module wb_port_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_mdu_wr_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [DEPTH-1:0] ent_v_q, ent_v_d;
  logic [4:0]      ent_rd_q [DEPTH];
  logic [4:0]      ent_rd_d [DEPTH];
  logic [31:0]     ent_data_q [DEPTH];
  logic [31:0]     ent_data_d [DEPTH];
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_wa_q, rf_wa_d;
  logic [31:0]     rf_wd_q, rf_wd_d;

  logic            full, pipe_win, push;
  logic [AW-1:0]   nxt;
  logic [1:0]      pop_n;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign mdu_ready  = !full;
  assign pipe_win   = wb_regwrite && (wb_rd != '0);
  assign push       = mdu_valid && !full && (mdu_rd != '0);
  assign nxt        = rd_ptr_q + AW'(1);
  assign pipe_stall = (state_q == S_FORCE);
  assign rf_we      = rf_we_q;
  assign rf_wa      = rf_wa_q;
  assign rf_wd      = rf_wd_q;

  always_comb begin
    ent_v_d    = ent_v_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rf_we_d    = 1'b0;
    rf_wa_d    = rf_wa_q;
    rf_wd_d    = rf_wd_q;
    pop_n      = 2'd0;
    if (pipe_win) begin
      rf_we_d = 1'b1;
      rf_wa_d = wb_rd;
      rf_wd_d = wb_data;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_rd_q[i] == wb_rd) ent_v_d[i] = 1'b0;
      end
    end else if (count_q != '0) begin
      if (ent_v_q[rd_ptr_q]) begin
        pop_n   = 2'd1;
        rf_we_d = 1'b1;
        rf_wa_d = ent_rd_q[rd_ptr_q];
        rf_wd_d = ent_data_q[rd_ptr_q];
      end else begin
        // A squashed head costs no slot; its successor may use this cycle.
        pop_n = 2'd1;
        if (count_q >= (AW+1)'(2) && ent_v_q[nxt]) begin
          pop_n   = 2'd2;
          rf_we_d = 1'b1;
          rf_wa_d = ent_rd_q[nxt];
          rf_wd_d = ent_data_q[nxt];
        end
      end
    end
    // Push lands after the squash so a same-cycle matching rd survives.
    if (push) begin
      ent_v_d[wr_ptr_q]    = 1'b1;
      ent_rd_d[wr_ptr_q]   = mdu_rd;
      ent_data_d[wr_ptr_q] = mdu_data;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    rd_ptr_d = rd_ptr_q + AW'(pop_n);
    count_d  = count_q - (AW+1)'(pop_n) + (AW+1)'(push);
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (count_d != '0) begin
          state_d = S_WAIT;
          wait_d  = '0;
        end
      end
      S_WAIT: begin
        if (count_d == '0) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end else if ((count_d == (AW+1)'(DEPTH)) ||
                     (pipe_win && wait_q == CW'(MAX_WAIT - 1))) begin
          state_d = S_FORCE;
          wait_d  = '0;
        end else if (pop_n != 2'd0) begin
          wait_d = '0;
        end else if (pipe_win) begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_FORCE: begin
        if (pop_n != 2'd0) begin
          state_d = (count_d == '0) ? S_IDLE : S_WAIT;
          wait_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ent_v_q    <= '0;
      ent_rd_q   <= '{default: '0};
      ent_data_q <= '{default: '0};
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ent_v_q    <= ent_v_d;
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
      rf_we_q    <= rf_we_d;
      rf_wa_q    <= rf_wa_d;
      rf_wd_q    <= rf_wd_d;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_mdu_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_q <= '0;
      perf_mdu_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + 32'(pipe_stall);
      perf_mdu_q   <= perf_mdu_q + 32'(rf_we_d && !pipe_win);
    end
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_mdu_wr_cnt = perf_mdu_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: scoreboard of expected register-file writes,
// pipeline writes pushed to the front (latency 1), MDU writes to the back.
module tb_wb_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  logic [36:0] sb [$];
  int          n_pass   = 0;
  int          n_checks = 0;
  logic [4:0]  t6_rd [6] = '{5'd0, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25};

  always #5 clock = ~clock;

  wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .mdu_valid   (mdu_valid),
    .mdu_rd      (mdu_rd),
    .mdu_data    (mdu_data),
    .mdu_ready   (mdu_ready),
    .pipe_stall  (pipe_stall),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd)
  );

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clock) begin
    logic [36:0] e;
    if (rf_we === 1'b1) begin
      e = 'x;
      if (sb.size() > 0) e = sb.pop_front();
      chk("rf_write", {rf_wa, rf_wd}, e);
    end
  end

  task automatic drive(input logic w, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    wb_regwrite = w;
    wb_rd       = wrd;
    wb_data     = wd;
    mdu_valid   = mv;
    mdu_rd      = mrd;
    mdu_data    = md;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic exp_pipe(input logic [4:0] rd, input logic [31:0] d);
    sb.push_front({rd, d});
  endtask

  task automatic exp_mdu(input logic [4:0] rd, input logic [31:0] d);
    sb.push_back({rd, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic stalled;
    int idx, m;
    logic wb, mv, acc, stored, pop;
    logic [4:0] rdv;

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("rst_we",    37'(rf_we), 37'(0));
    chk("rst_wa_wd", {rf_wa, rf_wd}, 37'(0));
    chk("rst_stall", 37'(pipe_stall), 37'(0));
    chk("rst_ready", 37'(mdu_ready), 37'(1));
    reset_n = 1'b1;
    tick();

    // 1: reset with three MDU results queued behind a busy pipeline
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd1, 32'h100 + i, 1, 5'(10 + i), 32'hC0 + i);
      exp_pipe(5'd1, 32'h100 + i);
      tick();
    end
    chk("t1_ready_q3", 37'(mdu_ready), 37'(1));
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("t1_async_we", 37'(rf_we), 37'(0));
    tick();
    reset_n = 1'b1;
    chk("t1_ready", 37'(mdu_ready), 37'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_no_write", 37'(rf_we), 37'(0));
    end

    // 2: idle pipeline, single MDU result drains
    drive(0, 0, 0, 1, 5'd5, 32'hA5A5_A5A5);
    exp_mdu(5'd5, 32'hA5A5_A5A5);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && sb.size() > 0; i++) tick();
    chk("t2_drain", 37'(sb.size()), 37'(0));
    chk("t2_last", {rf_wa, rf_wd}, {5'd5, 32'hA5A5_A5A5});

    // 3: pipeline and MDU in the same cycle
    drive(1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
    exp_mdu(5'd7, 32'h22);
    exp_pipe(5'd3, 32'h11);
    tick();
    chk("t3_T1", {rf_we, rf_wa, rf_wd[30:0]}, {1'b1, 5'd3, 31'h11});
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t3_T2", {rf_we, rf_wa, rf_wd[30:0]}, {1'b1, 5'd7, 31'h22});

    // 4: starvation forces a bubble
    n = 0;
    stalled = 1'b0;
    for (int c = 0; c < 20 && !stalled; c++) begin
      drive(1, 5'd1, 32'h400 + c, (c == 0), 5'd20, 32'hDEAD_0020);
      if (c == 0) exp_mdu(5'd20, 32'hDEAD_0020);
      exp_pipe(5'd1, 32'h400 + c);
      tick();
      n++;
      stalled = pipe_stall;
    end
    chk("t4_stall_after_push_plus_8", 37'(n), 37'(9));
    drive(1, 5'd2, 32'h4FF, 0, 0, 0);
    exp_pipe(5'd2, 32'h4FF);
    tick();
    chk("t4_force_hold", 37'(pipe_stall), 37'(1));
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t4_stall_drop", 37'(pipe_stall), 37'(0));
    chk("t4_drain", {rf_we, rf_wa, rf_wd[30:0]}, {1'b1, 5'd20, 31'h5EAD_0020});

    // 5: WAW squash, skip-over of a squashed head, same-cycle push survives
    drive(1, 5'd1, 32'h500, 1, 5'd9, 32'h9999_0009);
    exp_pipe(5'd1, 32'h500);
    tick();
    drive(1, 5'd9, 32'h599, 1, 5'd12, 32'hCC);
    exp_mdu(5'd12, 32'hCC);
    exp_pipe(5'd9, 32'h599);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_skip_squashed", {rf_we, rf_wa, rf_wd[30:0]}, {1'b1, 5'd12, 31'hCC});
    drive(1, 5'd14, 32'h514, 1, 5'd14, 32'h1414);
    exp_mdu(5'd14, 32'h1414);
    exp_pipe(5'd14, 32'h514);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_same_cycle_push", {rf_we, rf_wa, rf_wd[30:0]}, {1'b1, 5'd14, 31'h1414});
    tick();
    chk("t5_quiet", 37'(rf_we), 37'(0));

    // 6: fill the FIFO with a busy pipeline; rd=0 push is accepted but never written
    idx = 0;
    m   = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      wb  = (cyc < 5);
      mv  = (idx < 6);
      rdv = mv ? t6_rd[idx] : 5'd0;
      chk("t6_ready", 37'(mdu_ready), 37'(m < 4));
      drive(wb, 5'd1, 32'h600 + cyc, mv, rdv, 32'h6000_0000 | 32'(rdv));
      acc    = mv && (m < 4);
      stored = acc && (rdv != 5'd0);
      pop    = !wb && (m > 0);
      if (stored) exp_mdu(rdv, 32'h6000_0000 | 32'(rdv));
      if (wb) exp_pipe(5'd1, 32'h600 + cyc);
      m = m + int'(stored) - int'(pop);
      if (acc) idx++;
      tick();
      if (cyc == 4) chk("t6_force_on_full", {35'd0, pipe_stall, mdu_ready}, 37'b10);
      if (cyc == 5) chk("t6_force_exit", 37'(pipe_stall), 37'(0));
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8 && sb.size() > 0; i++) tick();
    chk("t6_all_drained", 37'(sb.size()), 37'(0));
    chk("t6_end_state", {35'd0, pipe_stall, mdu_ready}, 37'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
